// File: rtl/imm_ext_unit.sv
// Registered immediate sign-extension unit: two independent extension paths,
// negation and a self-check sum, all captured with one cycle of latency.
module imm_ext_unit #(
  parameter int IMM_W = 12,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  output logic [XLEN-1:0]  ext_imm,
  output logic [XLEN-1:0]  ext_imm2,
  output logic [XLEN-1:0]  minus_ext_imm,
  output logic [XLEN-1:0]  zero,
  output logic             ext_mismatch,
  output logic             zero_err
);

  logic [XLEN-1:0]         ext_a_next;
  logic [XLEN-1:0]         ext_b_next;
  logic [XLEN-1:0]         minus_next;
  logic [XLEN-1:0]         zero_next;
  logic                    mismatch_next;
  logic                    zero_err_next;
  logic signed [IMM_W-1:0] imm_signed;

  // Path A: explicit bit replication of the sign bit into the upper field.
  assign ext_a_next[IMM_W-1:0] = imm;
  generate
    for (genvar gi = IMM_W; gi < XLEN; gi++) begin : g_sign_rep
      assign ext_a_next[gi] = imm[IMM_W-1];
    end
  endgenerate

  // Path B: arithmetic widening of a signed-typed copy, kept structurally
  // separate from path A so the two can cross-check each other.
  assign imm_signed = $signed(imm);
  assign ext_b_next = XLEN'(imm_signed);

  assign minus_next    = ~ext_a_next + XLEN'(1);
  assign zero_next     = ext_a_next + minus_next;
  assign mismatch_next = (ext_a_next != ext_b_next);
  assign zero_err_next = (zero_next != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      ext_imm       <= '0;
      ext_imm2      <= '0;
      minus_ext_imm <= '0;
      zero          <= '0;
      ext_mismatch  <= 1'b0;
      zero_err      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ext_imm       <= ext_a_next;
        ext_imm2      <= ext_b_next;
        minus_ext_imm <= minus_next;
        zero          <= zero_next;
        ext_mismatch  <= mismatch_next;
        zero_err      <= zero_err_next;
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed and exhaustive checks of imm_ext_unit against hand-computed values.
module tb_imm_ext_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [11:0] imm;
  logic        out_valid;
  logic [31:0] ext_imm;
  logic [31:0] ext_imm2;
  logic [31:0] minus_ext_imm;
  logic [31:0] zero;
  logic        ext_mismatch;
  logic        zero_err;

  int n_cmp = 0;
  int n_err = 0;

  imm_ext_unit #(.IMM_W(12), .XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .imm(imm),
    .out_valid(out_valid),
    .ext_imm(ext_imm),
    .ext_imm2(ext_imm2),
    .minus_ext_imm(minus_ext_imm),
    .zero(zero),
    .ext_mismatch(ext_mismatch),
    .zero_err(zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge, then sample 1 time unit
  // after the following rising edge.
  task automatic step(input logic r, input logic v, input logic [11:0] d);
    @(negedge clk);
    rst = r;
    in_valid = v;
    imm = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, 12'h123);
      n_cmp++;
      if ({out_valid, ext_imm, ext_imm2, minus_ext_imm, zero, ext_mismatch, zero_err} !== '0) begin
        n_err++;
        $display("FAIL reset cycle %0d: got valid=%b ext=%h ext2=%h minus=%h zero=%h mm=%b ze=%b, want all 0",
                 c, out_valid, ext_imm, ext_imm2, minus_ext_imm, zero, ext_mismatch, zero_err);
      end
      $display("reset cycle %0d: valid=%b ext=%h", c, out_valid, ext_imm);
    end
  endtask

  task automatic test_directed();
    logic [11:0] vi [11];
    logic [31:0] ve [11];
    logic [31:0] vm [11];
    vi = '{12'd5, 12'd12, 12'd1337, 12'hFFB, 12'hFF4, 12'h81D,
           12'h000, 12'h7FF, 12'h800, 12'hFFF, 12'd5};
    ve = '{32'h00000005, 32'h0000000C, 32'h00000539, 32'hFFFFFFFB, 32'hFFFFFFF4,
           32'hFFFFF81D, 32'h00000000, 32'h000007FF, 32'hFFFFF800, 32'hFFFFFFFF,
           32'h00000005};
    vm = '{32'hFFFFFFFB, 32'hFFFFFFF4, 32'hFFFFFAC7, 32'h00000005, 32'h0000000C,
           32'h000007E3, 32'h00000000, 32'hFFFFF801, 32'h00000800, 32'h00000001,
           32'hFFFFFFFB};
    for (int k = 0; k < 11; k++) begin
      step(1'b0, 1'b1, vi[k]);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL directed valid imm=%h: got %b want 1", vi[k], out_valid);
      end
      n_cmp++;
      if (ext_imm !== ve[k]) begin
        n_err++;
        $display("FAIL directed ext_imm imm=%h: got %h want %h", vi[k], ext_imm, ve[k]);
      end
      n_cmp++;
      if (ext_imm2 !== ve[k]) begin
        n_err++;
        $display("FAIL directed ext_imm2 imm=%h: got %h want %h", vi[k], ext_imm2, ve[k]);
      end
      n_cmp++;
      if (minus_ext_imm !== vm[k]) begin
        n_err++;
        $display("FAIL directed minus imm=%h: got %h want %h", vi[k], minus_ext_imm, vm[k]);
      end
      n_cmp++;
      if (zero !== 32'h0 || ext_mismatch !== 1'b0 || zero_err !== 1'b0) begin
        n_err++;
        $display("FAIL directed checks imm=%h: got zero=%h mm=%b ze=%b want 0/0/0",
                 vi[k], zero, ext_mismatch, zero_err);
      end
      $display("directed imm=%h: ext=%h ext2=%h minus=%h zero=%h", vi[k], ext_imm, ext_imm2,
               minus_ext_imm, zero);
    end
  endtask

  task automatic test_valid_gating();
    step(1'b0, 1'b1, 12'd5);
    n_cmp++;
    if (out_valid !== 1'b1 || ext_imm !== 32'h5) begin
      n_err++;
      $display("FAIL gating load: got valid=%b ext=%h want 1/00000005", out_valid, ext_imm);
    end
    $display("gating imm=5 v=1: valid=%b ext=%h", out_valid, ext_imm);
    step(1'b0, 1'b0, 12'd7);
    n_cmp++;
    if (out_valid !== 1'b0 || ext_imm !== 32'h5 || minus_ext_imm !== 32'hFFFFFFFB) begin
      n_err++;
      $display("FAIL gating hold: got valid=%b ext=%h minus=%h want 0/00000005/fffffffb",
               out_valid, ext_imm, minus_ext_imm);
    end
    $display("gating imm=7 v=0: valid=%b ext=%h", out_valid, ext_imm);
    step(1'b1, 1'b1, 12'd9);
    n_cmp++;
    if (out_valid !== 1'b0 || ext_imm !== 32'h0 || minus_ext_imm !== 32'h0) begin
      n_err++;
      $display("FAIL gating reset: got valid=%b ext=%h minus=%h want 0/0/0",
               out_valid, ext_imm, minus_ext_imm);
    end
    $display("gating rst with imm=9: valid=%b ext=%h", out_valid, ext_imm);
    step(1'b0, 1'b0, 12'd9);
    n_cmp++;
    if (out_valid !== 1'b0 || ext_imm !== 32'h0) begin
      n_err++;
      $display("FAIL gating post-reset idle: got valid=%b ext=%h want 0/0", out_valid, ext_imm);
    end
    $display("gating idle after rst: valid=%b ext=%h", out_valid, ext_imm);
    step(1'b0, 1'b1, 12'hFFD);
    n_cmp++;
    if (out_valid !== 1'b1 || ext_imm !== 32'hFFFFFFFD || minus_ext_imm !== 32'h3) begin
      n_err++;
      $display("FAIL gating first after reset: got valid=%b ext=%h minus=%h want 1/fffffffd/00000003",
               out_valid, ext_imm, minus_ext_imm);
    end
    $display("gating imm=ffd v=1: valid=%b ext=%h", out_valid, ext_imm);
  endtask

  task automatic test_sweep();
    int sweep_bad;
    int v;
    logic [31:0] exp_ext;
    logic [31:0] exp_minus;
    sweep_bad = 0;
    for (int i = 0; i < 4096; i++) begin
      step(1'b0, 1'b1, 12'(i));
      v = (i < 2048) ? i : i - 4096;
      exp_ext = 32'(v);
      exp_minus = 32'(-v);
      n_cmp++;
      if (out_valid !== 1'b1 || ext_imm !== exp_ext || ext_imm2 !== exp_ext ||
          minus_ext_imm !== exp_minus || zero !== 32'h0 ||
          ext_mismatch !== 1'b0 || zero_err !== 1'b0) begin
        n_err++;
        sweep_bad++;
        $display("FAIL sweep imm=%h: got v=%b ext=%h ext2=%h minus=%h zero=%h mm=%b ze=%b want 1/%h/%h/%h/0/0/0",
                 12'(i), out_valid, ext_imm, ext_imm2, minus_ext_imm, zero, ext_mismatch,
                 zero_err, exp_ext, exp_ext, exp_minus);
      end
    end
    $display("sweep of 4096 immediates: %0d bad cycles", sweep_bad);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    imm = '0;
    test_reset();
    test_directed();
    test_valid_gating();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
